// File: rtl/conv_pkg.sv
// conv_pkg: shared constants and FSM state encoding for the result-bank readout sequencer
package conv_pkg;
  localparam int N_REGS = 64;
  localparam int DATA_W = 16;
  localparam int SEL_W  = $clog2(N_REGS);
  localparam int CNT_W  = $clog2(N_REGS) + 1;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_DONE} state_t;
endpackage

// File: rtl/conv_out_readout_seq_if.sv
// conv_out_readout_seq_if: mux select/return path plus the valid/ready output stream
interface conv_out_readout_seq_if;
  import conv_pkg::*;
  logic [SEL_W-1:0]  MUX_Sel;
  logic [DATA_W-1:0] MUX_Out;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  modport master (output MUX_Sel, out_data, out_valid, input MUX_Out, out_ready);
  modport slave  (input MUX_Sel, out_data, out_valid, output MUX_Out, out_ready);
endinterface

// File: rtl/conv_out_readout_seq.sv
// conv_out_readout_seq: walks the 64:1 result mux and streams the selected words out
module conv_out_readout_seq
  import conv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CNT_W-1:0]      cfg_len,
  conv_out_readout_seq_if.master bus,
  output logic                  reg_hold,
  output logic                  busy,
  output logic                  done
);
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  len_q, len_d, sent_q, sent_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              accept;
  assign accept        = valid_q & bus.out_ready;
  assign bus.MUX_Sel   = sel_q;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      sent_q  <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      sent_q  <= sent_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end
  // next state; abort from any active state wins over a coincident accept
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    sent_d  = sent_q;
    sel_d   = sel_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (start && !abort) begin
          if (cfg_len == '0) state_d = ST_DONE;
          else begin
            len_d   = cfg_len > CNT_W'(N_REGS) ? CNT_W'(N_REGS) : cfg_len;
            sel_d   = '0;
            sent_d  = '0;
            state_d = ST_LOAD;
          end
        end
        ST_LOAD: begin
          data_d  = bus.MUX_Out;
          valid_d = 1'b1;
          sel_d   = sel_q + SEL_W'(1);
          state_d = ST_SEND;
        end
        ST_SEND: if (accept) begin
          sent_d = sent_q + CNT_W'(1);
          if (sent_q == len_q - CNT_W'(1)) begin
            valid_d = 1'b0;
            state_d = ST_DONE;
          end else begin
            data_d = bus.MUX_Out;
            sel_d  = sel_q + SEL_W'(1);
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end
  // status outputs decoded from the state register only
  always_comb begin
    busy     = state_q != ST_IDLE;
    reg_hold = state_q != ST_IDLE;
    done     = state_q == ST_DONE;
  end
endmodule

// File: tb/tb_conv_out_readout_seq.sv
// tb_conv_out_readout_seq: scoreboard bench with a modelled 64:1 mux (reg i = A000+i)
module tb_conv_out_readout_seq;
  import conv_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [CNT_W-1:0] cfg_len = '0;
  logic reg_hold, busy, done;
  logic rnd_en = 1'b0, rnd_bit = 1'b0, ready_fix = 1'b1;
  int checks = 0, errors = 0, acc_cnt = 0, done_cnt = 0, valid_cnt = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_w, prev_data = '0;
  logic [SEL_W-1:0]  prev_sel = '0;
  logic prev_stall = 1'b0;
  conv_out_readout_seq_if bus();
  assign bus.MUX_Out   = 16'hA000 + 16'(bus.MUX_Sel);
  assign bus.out_ready = rnd_en ? rnd_bit : ready_fix;
  conv_out_readout_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cfg_len(cfg_len),
    .bus(bus), .reg_hold(reg_hold), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1 rnd_bit = 1'($urandom_range(0, 1));
  end
  always @(negedge clk) begin
    if (rst_n) begin
      done_cnt  += int'(done);
      valid_cnt += int'(bus.out_valid);
      if (prev_stall) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data || bus.MUX_Sel !== prev_sel) begin
          errors++;
          $display("FAIL stall_hold: valid=%b data=%h sel=%0d, required valid=1 data=%h sel=%0d",
                   bus.out_valid, bus.out_data, bus.MUX_Sel, prev_data, prev_sel);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready && !abort;
      prev_data  = bus.out_data;
      prev_sel   = bus.MUX_Sel;
      if (bus.out_valid && bus.out_ready && !abort) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got %h, none expected", bus.out_data);
        end else begin
          exp_w = exp_q.pop_front();
          if (bus.out_data !== exp_w) begin
            errors++;
            $display("FAIL word: got %h, expected %h", bus.out_data, exp_w);
          end
        end
        acc_cnt++;
      end
    end else prev_stall = 1'b0;
  end
  task automatic push_exp(input int len);
    for (int i = 0; i < (len > N_REGS ? N_REGS : len); i++) exp_q.push_back(16'hA000 + 16'(i));
  endtask
  task automatic pulse_start(input int len);
    @(posedge clk); #1;
    cfg_len = CNT_W'(len);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask
  task automatic wait_done(input int budget, input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < budget);
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
    end
  endtask
  task automatic wait_acc(input int target);
    int b = 0;
    while (acc_cnt < target && b < 200) begin
      @(posedge clk);
      b++;
    end
    checks++;
    if (acc_cnt != target) begin
      errors++;
      $display("FAIL acc_wait: accepts=%0d, required %0d", acc_cnt, target);
    end
  endtask
  task automatic test_reset();
    #2;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.MUX_Sel !== '0 || busy !== 1'b0 ||
        reg_hold !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b data=%h sel=%0d busy=%b hold=%b done=%b, required all 0",
               bus.out_valid, bus.out_data, bus.MUX_Sel, busy, reg_hold, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_full_len();
    int n;
    acc_cnt = 0;
    done_cnt = 0;
    ready_fix = 1'b1;
    push_exp(64);
    pulse_start(64);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b1 || reg_hold !== 1'b1) begin
      errors++;
      $display("FAIL latency_1: valid=%b busy=%b hold=%b, required 0 1 1", bus.out_valid, busy, reg_hold);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency_2: valid=%b, required 1", bus.out_valid);
    end
    wait_done(200, "full", n);
    checks++;
    if (n + 2 != 66) begin
      errors++;
      $display("FAIL full_cycles: start->done %0d cycles, required 66", n + 2);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL full_idle: busy=%b done=%b, required 0 0", busy, done);
    end
    @(posedge clk);
    checks++;
    if (done_cnt != 1 || acc_cnt != 64 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL full_count: done=%0d words=%0d left=%0d, required 1 64 0", done_cnt, acc_cnt, exp_q.size());
    end
  endtask
  task automatic test_random_ready();
    int n;
    done_cnt = 0;
    acc_cnt = 0;
    rnd_en = 1'b1;
    push_exp(5);
    pulse_start(5);
    wait_done(300, "random", n);
    rnd_en = 1'b0;
    @(posedge clk);
    checks++;
    if (done_cnt != 1 || acc_cnt != 5 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL random_count: done=%0d words=%0d left=%0d, required 1 5 0", done_cnt, acc_cnt, exp_q.size());
    end
  endtask
  task automatic test_len_edges();
    int n;
    done_cnt = 0;
    valid_cnt = 0;
    pulse_start(0);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: done=%b valid=%b, required 1 0", done, bus.out_valid);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_idle: done=%b busy=%b, required 0 0", done, busy);
    end
    @(posedge clk);
    checks++;
    if (valid_cnt != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL zero_count: valid cycles=%0d dones=%0d, required 0 1", valid_cnt, done_cnt);
    end
    acc_cnt = 0;
    push_exp(100);
    pulse_start(100);
    wait_done(200, "clip", n);
    @(posedge clk);
    checks++;
    if (acc_cnt != 64 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL clip_count: words=%0d left=%0d, required 64 0", acc_cnt, exp_q.size());
    end
  endtask
  task automatic test_abort();
    done_cnt = 0;
    acc_cnt = 0;
    push_exp(64);
    pulse_start(64);
    wait_acc(10);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || reg_hold !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: valid=%b busy=%b hold=%b, required 0 0 0", bus.out_valid, busy, reg_hold);
    end
    repeat (3) @(posedge clk);
    checks++;
    if (done_cnt != 0 || acc_cnt != 10 || exp_q.size() != 54) begin
      errors++;
      $display("FAIL abort_count: dones=%0d words=%0d left=%0d, required 0 10 54", done_cnt, acc_cnt, exp_q.size());
    end
    exp_q.delete();
  endtask
  task automatic test_async_reset();
    int n;
    acc_cnt = 0;
    push_exp(64);
    pulse_start(64);
    wait_acc(5);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.MUX_Sel !== '0 || busy !== 1'b0 ||
        reg_hold !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: valid=%b data=%h sel=%0d busy=%b hold=%b done=%b, required all 0",
               bus.out_valid, bus.out_data, bus.MUX_Sel, busy, reg_hold, done);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    acc_cnt = 0;
    done_cnt = 0;
    push_exp(3);
    pulse_start(3);
    wait_done(50, "restart", n);
    @(posedge clk);
    checks++;
    if (acc_cnt != 3 || exp_q.size() != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL restart_count: words=%0d left=%0d dones=%0d, required 3 0 1", acc_cnt, exp_q.size(), done_cnt);
    end
  endtask
  task automatic test_start_busy();
    int n;
    acc_cnt = 0;
    done_cnt = 0;
    push_exp(8);
    pulse_start(8);
    repeat (3) @(posedge clk);
    #1 cfg_len = CNT_W'(3);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(50, "busy_start", n);
    repeat (5) @(posedge clk);
    checks++;
    if (acc_cnt != 8 || exp_q.size() != 0 || done_cnt != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_start: words=%0d left=%0d dones=%0d busy=%b, required 8 0 1 0",
               acc_cnt, exp_q.size(), done_cnt, busy);
    end
  endtask
  initial begin
    test_reset();
    test_full_len();
    test_random_ready();
    test_len_edges();
    test_abort();
    test_async_reset();
    test_start_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
